// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand width and the iteration-counter sizing helper.
package booth_seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Counter must hold 0..width so the last iteration index is representable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_seq_divider_div_nr_step.sv
// One combinational non-restoring division step on unsigned magnitudes:
// shift {P,Q} left, add or subtract the divisor, shift in the new quotient bit.
module booth_seq_divider_div_nr_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   dvs_mag,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] p_shift;

  assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  // The add/subtract choice follows the sign of P before the shift.
  assign p_next  = p[WIDTH] ? (p_shift + dvs_mag) : (p_shift - dvs_mag);
  assign q_next  = {q[WIDTH-2:0], ~p_next[WIDTH]};

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: one non-restoring step per clock, quotient
// truncated toward zero, remainder taking the sign of the dividend.
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   dvs_mag;
  logic             q_neg;
  logic             r_neg;
  logic             fin;
  logic             zero_fin;

  // Magnitudes are WIDTH+1 bits so |most-negative| is representable.
  logic [WIDTH:0]   dvd_ext;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   dvd_abs;
  logic [WIDTH:0]   dvs_abs;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;

  assign dvd_ext = {dvd_r[WIDTH-1], dvd_r};
  assign dvs_ext = {dvs_r[WIDTH-1], dvs_r};
  assign dvd_abs = dvd_ext[WIDTH] ? -dvd_ext : dvd_ext;
  assign dvs_abs = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
  assign p_fix   = p[WIDTH] ? (p + dvs_mag) : p;

  booth_seq_divider_div_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p       (p),
    .q       (q),
    .dvs_mag (dvs_mag),
    .p_next  (p_step),
    .q_next  (q_step)
  );

  // NOTE: every state and datapath register sits in this one clocked block and
  // is updated with <=, so all right-hand sides see pre-edge values.
  // NOTE: internal registers are reset too, so no output can ever leak an X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      p           <= '0;
      q           <= '0;
      dvs_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      fin         <= 1'b0;
      zero_fin    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;

      // Results land on the outputs one cycle after the FSM finishes.
      if (fin) begin
        fin      <= 1'b0;
        zero_fin <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        if (zero_fin) begin
          quotient    <= '1;
          remainder   <= dvd_r;
          div_by_zero <= 1'b1;
        end else begin
          quotient  <= q_neg ? -q : q;
          remainder <= r_neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        end
      end

      case (state)
        ST_IDLE: begin
          // busy is still high during the result-publish cycle, so a start
          // there is ignored; the cycle that shows done has busy low.
          if (start && !busy) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (dvs_r == '0) begin
            fin      <= 1'b1;
            zero_fin <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            dvs_mag <= dvs_abs;
            q       <= dvd_abs[WIDTH-1:0];
            q_neg   <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
            r_neg   <= dvd_r[WIDTH-1];
            p       <= '0;
            cnt     <= '0;
            state   <= ST_ITER;
          end
        end
        ST_ITER: begin
          p   <= p_step;
          q   <= q_step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          p     <= p_fix;
          fin   <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Bench for booth_seq_divider: WIDTH=8 and WIDTH=4 instances checked every
// cycle against an arithmetic model, plus hand-computed directed cases.
module tb_booth_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0, dvs8 = '0;
  logic [7:0] quotient8, remainder8;
  logic       busy8, done8, dbz8;

  logic       start4 = 1'b0;
  logic [3:0] dvd4 = '0, dvs4 = '0;
  logic [3:0] quotient4, remainder4;
  logic       busy4, done4, dbz4;

  booth_seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .quotient(quotient8), .remainder(remainder8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8)
  );

  booth_seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .quotient(quotient4), .remainder(remainder4), .busy(busy4), .done(done4),
    .div_by_zero(dbz4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows the dividend), results reduced to w bits.
  function automatic void ref_div(input int a, input int b, input int w,
                                  output bit [31:0] q, output bit [31:0] r, output bit z);
    bit [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (b == 0) begin
      q = mask;
      r = 32'(a) & mask;
      z = 1'b1;
    end else begin
      q = 32'(a / b) & mask;
      r = 32'(a % b) & mask;
      z = 1'b0;
    end
  endfunction

  // Model of the visible behaviour: fixed latency, held results, busy window.
  bit        m_busy[2], m_done[2], m_dbz[2];
  bit [31:0] m_q[2], m_r[2], p_q[2], p_r[2];
  bit        p_z[2];
  int        m_cnt[2];

  always @(posedge clk or negedge rst_n) begin
    int w, a, b;
    bit st;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_done[k] = 0; m_dbz[k] = 0;
        m_q[k] = 0; m_r[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          w = 8; st = start8; a = $signed(dvd8); b = $signed(dvs8);
        end else begin
          w = 4; st = start4; a = $signed(dvd4); b = $signed(dvs4);
        end
        m_done[k] = 0;
        if (m_busy[k]) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_q[k] = p_q[k];
            m_r[k] = p_r[k];
            m_dbz[k] = p_z[k];
          end
        end else if (st) begin
          ref_div(a, b, w, p_q[k], p_r[k], p_z[k]);
          m_busy[k] = 1;
          m_dbz[k] = 0;
          m_cnt[k] = (b == 0) ? 2 : w + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("w8 busy", 32'(busy8), 32'(m_busy[0]));
      check("w8 done", 32'(done8), 32'(m_done[0]));
      check("w8 div_by_zero", 32'(dbz8), 32'(m_dbz[0]));
      check("w8 quotient", 32'(quotient8), m_q[0]);
      check("w8 remainder", 32'(remainder8), m_r[0]);
      check("w4 busy", 32'(busy4), 32'(m_busy[1]));
      check("w4 done", 32'(done4), 32'(m_done[1]));
      check("w4 div_by_zero", 32'(dbz4), 32'(m_dbz[1]));
      check("w4 quotient", 32'(quotient4), m_q[1]);
      check("w4 remainder", 32'(remainder4), m_r[1]);
    end
  end

  // One WIDTH=8 operation; lat counts edges from the accepting edge to the
  // edge that raised done, bc counts cycles with busy high.
  task automatic op8(input int a, input int b, input int inject,
                     output logic [7:0] q, output logic [7:0] r, output logic z,
                     output int lat, output int bc);
    @(negedge clk);
    dvd8 = 8'(a);
    dvs8 = 8'(b);
    start8 = 1'b1;
    @(posedge clk);
    lat = 0;
    bc = 0;
    @(negedge clk);
    start8 = 1'b0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8) bc++;
      start8 = (lat == inject);
      if (start8) begin
        dvd8 = 8'd20;
        dvs8 = 8'd4;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start8 = 1'b0;
    q = quotient8;
    r = remainder8;
    z = dbz8;
  endtask

  task automatic op4(input int a, input int b, output logic [3:0] q,
                     output logic [3:0] r, output int lat);
    @(negedge clk);
    dvd4 = 4'(a);
    dvs4 = 4'(b);
    start4 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start4 = 1'b0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = quotient4;
    r = remainder4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q, r;
    logic [3:0] q4, r4;
    logic       z;
    int         lat, bc, n, pair;
    int         order[256];

    #1;
    check("reset quotient", 32'(quotient8), 32'h0);
    check("reset remainder", 32'(remainder8), 32'h0);
    check("reset busy/done/flag", {29'b0, busy8, done8, dbz8}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    op8(100, 7, -1, q, r, z, lat, bc);
    check("100/7 q", 32'(q), 32'd14);
    check("100/7 r", 32'(r), 32'd2);
    check("100/7 flag", 32'(z), 32'd0);
    check("100/7 latency", 32'(lat), 32'd11);
    check("100/7 busy cycles", 32'(bc), 32'd11);

    op8(-100, 7, -1, q, r, z, lat, bc);
    check("-100/7 q", 32'(q), 32'hF2);
    check("-100/7 r", 32'(r), 32'hFE);
    op8(100, -7, -1, q, r, z, lat, bc);
    check("100/-7 q", 32'(q), 32'hF2);
    check("100/-7 r", 32'(r), 32'h02);

    op8(-128, -1, -1, q, r, z, lat, bc);
    check("-128/-1 q", 32'(q), 32'h80);
    check("-128/-1 r", 32'(r), 32'h00);
    check("-128/-1 flag", 32'(z), 32'd0);
    op8(-128, 1, -1, q, r, z, lat, bc);
    check("-128/1 q", 32'(q), 32'h80);
    check("-128/1 r", 32'(r), 32'h00);
    op8(3, -9, -1, q, r, z, lat, bc);
    check("3/-9 q", 32'(q), 32'h00);
    check("3/-9 r", 32'(r), 32'h03);

    op8(5, 0, -1, q, r, z, lat, bc);
    check("5/0 latency", 32'(lat), 32'd2);
    check("5/0 q", 32'(q), 32'hFF);
    check("5/0 r", 32'(r), 32'h05);
    check("5/0 flag", 32'(z), 32'd1);
    op8(6, 3, -1, q, r, z, lat, bc);
    check("6/3 q", 32'(q), 32'h02);
    check("6/3 r", 32'(r), 32'h00);
    check("6/3 flag cleared", 32'(z), 32'd0);

    op8(50, 3, 4, q, r, z, lat, bc);
    check("50/3 ignored start q", 32'(q), 32'd16);
    check("50/3 ignored start r", 32'(r), 32'd2);
    check("50/3 ignored start latency", 32'(lat), 32'd11);

    // Random start pulses, including ones landing while busy.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 3) == 0);
      dvd8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      case ($urandom_range(0, 9))
        0:       dvs8 = 8'h00;
        1:       dvs8 = 8'hFF;
        default: dvs8 = 8'($urandom);
      endcase
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (15) @(negedge clk);

    op4(7, 2, q4, r4, lat);
    check("w4 7/2 q", 32'(q4), 32'd3);
    check("w4 7/2 r", 32'(r4), 32'd1);
    check("w4 latency", 32'(lat), 32'd7);
    op4(-8, -1, q4, r4, lat);
    check("w4 -8/-1 q", 32'(q4), 32'h8);
    check("w4 -8/-1 r", 32'(r4), 32'h0);

    // All 256 WIDTH=4 operand pairs in shuffled order; the next start is
    // driven in the done cycle unless a random gap is inserted.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      pair = order[i];
      dvd4 = 4'(pair >> 4);
      dvs4 = 4'(pair);
      start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("w4 done timeout", 32'(n), 32'd0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // Abort mid-operation with reset: outputs clear at once, no done follows.
    @(negedge clk);
    dvd8 = 8'd77;
    dvs8 = 8'd5;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort quotient", 32'(quotient8), 32'h0);
    check("abort remainder", 32'(remainder8), 32'h0);
    check("abort busy/done/flag", {29'b0, busy8, done8, dbz8}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("abort done during reset", 32'(done8), 32'd0);
    end
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
